// File: rtl/llr_sm_to_tc_stream.sv
`timescale 1ns/1ps
// Sign-magnitude to two's-complement LLR stream converter with magnitude clipping,
// a two-entry output buffer (output + skid register), and codeword framing.
module llr_sm_to_tc_stream #(
    parameter int W         = 9,
    parameter int FRAME_LEN = 1024,
    parameter int MAX_MAG   = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         frame_done,
    output logic         sat_flag
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds data stable while valid is high and ready is low.

    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [W-2:0] MAX_M = (W-1)'(MAX_MAG);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    logic [CW-1:0] cnt;
    logic          sk_valid;
    logic [W-1:0]  sk_data;
    logic          sk_last;

    logic          accept;
    logic          emit;
    logic          clip;
    logic          is_last;
    logic [W-2:0]  mag_clip;
    logic [W-1:0]  conv;

    always_comb begin
        accept   = in_valid & in_ready;
        emit     = out_valid & out_ready;
        clip     = in_data[W-2:0] > MAX_M;
        mag_clip = clip ? MAX_M : in_data[W-2:0];
        is_last  = (cnt == LAST_CNT);
        // Negative zero folds to plain zero rather than producing a spurious -0.
        if (in_data[W-1] && (mag_clip != '0)) begin
            conv = ~{1'b0, mag_clip} + {{(W-1){1'b0}}, 1'b1};
        end else begin
            conv = {1'b0, mag_clip};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            sk_valid   <= 1'b0;
            sk_data    <= '0;
            sk_last    <= 1'b0;
            cnt        <= '0;
            frame_done <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            frame_done <= emit & out_last;

            if (emit) begin
                if (sk_valid) begin
                    out_data <= sk_data;
                    out_last <= sk_last;
                    sk_valid <= 1'b0;
                    in_ready <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end

            // accept implies the skid is empty, since in_ready mirrors ~sk_valid.
            if (accept) begin
                if (!out_valid || emit) begin
                    out_valid <= 1'b1;
                    out_data  <= conv;
                    out_last  <= is_last;
                end else begin
                    sk_valid <= 1'b1;
                    sk_data  <= conv;
                    sk_last  <= is_last;
                    in_ready <= 1'b0;
                end
                cnt      <= is_last ? '0 : cnt + CW'(1);
                sat_flag <= (cnt == '0) ? clip : (sat_flag | clip);
            end
        end
    end

endmodule

// File: tb/tb_llr_sm_to_tc_stream.sv
`timescale 1ns/1ps
// Scoreboard bench for llr_sm_to_tc_stream: directed conversion/clip, throughput,
// backpressure, random handshake and mid-frame reset scenarios.
module tb_llr_sm_to_tc_stream;
    localparam int W         = 9;
    localparam int FRAME_LEN = 8;
    localparam int MAX_MAG   = 100;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_ready;
    logic         frame_done;
    logic         sat_flag;

    llr_sm_to_tc_stream #(.W(W), .FRAME_LEN(FRAME_LEN), .MAX_MAG(MAX_MAG)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .frame_done(frame_done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] sm2tc(input logic [W-1:0] x);
        int m;
        int v;
        m = int'(x[W-2:0]);
        if (m > MAX_MAG) m = MAX_MAG;
        v = x[W-1] ? -m : m;
        return v[W-1:0];
    endfunction

    // Scoreboard state: {last, data} of every accepted but not yet emitted sample.
    logic [W:0]   exp_q[$];
    logic [W-1:0] drv_exp;
    logic         mon_on = 1'b0;
    int           mcnt = 0;
    logic         msat = 1'b0;
    logic         exp_fd = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W:0]   held = '0;
    int           cyc = 0;
    int           fire_cnt = 0, first_fire = -1, last_fire = -1;
    int           acc_cnt = 0, first_acc = -1, fd_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (mon_on) begin
            check("in_ready", in_ready, exp_q.size() < 2);
            check("out_valid", out_valid, exp_q.size() > 0);
            check("frame_done", frame_done, exp_fd);
            check("sat_flag", sat_flag, msat);
            if (prev_stall && out_valid) check("hold", {out_last, out_data}, held);
            if (frame_done) fd_cnt++;
            if (rst) begin
                exp_q.delete();
                mcnt = 0;
                msat = 1'b0;
                exp_fd = 1'b0;
                prev_stall = 1'b0;
            end else begin
                exp_fd = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", {out_last, out_data}, 32'hFFFF_FFFF);
                    end else begin
                        check("data", {out_last, out_data}, exp_q.pop_front());
                    end
                    exp_fd = out_last;
                    if (first_fire < 0) first_fire = cyc;
                    last_fire = cyc;
                    fire_cnt++;
                end
                prev_stall = out_valid && !out_ready;
                held = {out_last, out_data};
                if (in_valid && in_ready) begin
                    exp_q.push_back({mcnt == FRAME_LEN - 1, drv_exp});
                    if (mcnt == 0) msat = (in_data[W-2:0] > MAX_MAG);
                    else msat = msat | (in_data[W-2:0] > MAX_MAG);
                    mcnt = (mcnt == FRAME_LEN - 1) ? 0 : mcnt + 1;
                    if (first_acc < 0) first_acc = cyc;
                    acc_cnt++;
                end
            end
        end
    end

    // All driver tasks start and end one time unit after a rising edge.
    task automatic send(input logic [W-1:0] d, input logic [W-1:0] e);
        logic hs;
        in_valid = 1'b1;
        in_data  = d;
        drv_exp  = e;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) return;
        end
        check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!out_valid && exp_q.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_stats();
        fire_cnt = 0; first_fire = -1; last_fire = -1;
        acc_cnt = 0; first_acc = -1; fd_cnt = 0;
    endtask

    logic [W-1:0] tab_in  [8] = '{9'h0C8, 9'h1C8, 9'h005, 9'h105, 9'h1FF, 9'h100, 9'h000, 9'h064};
    logic [W-1:0] tab_exp [8] = '{9'h064, 9'h19C, 9'h005, 9'h1FB, 9'h19C, 9'h000, 9'h000, 9'h064};

    initial begin
        logic [W-1:0] r;
        int stall_acc;
        logic hs;
        int n;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; drv_exp = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        mon_on = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_sat_flag", sat_flag, 0);
        @(posedge clk); #1;

        // Directed conversion and clipping; one full frame, then first sample of the next.
        out_ready = 1'b1;
        send(tab_in[0], tab_exp[0]);
        in_valid = 1'b0;
        @(negedge clk);
        check("sat_set", sat_flag, 1);
        @(posedge clk); #1;
        for (int i = 1; i < 8; i++) send(tab_in[i], tab_exp[i]);
        send(9'h005, 9'h005);
        in_valid = 1'b0;
        @(negedge clk);
        check("sat_clear", sat_flag, 0);
        @(posedge clk); #1;
        send(9'h1E4, 9'h19C);
        drain();

        // Throughput: 16 back-to-back samples from a frame boundary.
        pulse_reset();
        clear_stats();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            r = W'($urandom_range(0, 511));
            send(r, sm2tc(r));
        end
        drain();
        check("tp_count", fire_cnt, 16);
        check("tp_span", last_fire - first_fire, 15);
        check("tp_latency", first_fire - first_acc, 1);
        check("tp_frame_done", fd_cnt, 2);

        // Backpressure: start from an empty buffer, then stall downstream for 5 cycles.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r = W'($urandom_range(0, 511));
            send(r, sm2tc(r));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        stall_acc = 0;
        r = W'($urandom_range(0, 511));
        in_valid = 1'b1; in_data = r; drv_exp = sm2tc(r);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk); #1;
            if (hs) begin
                stall_acc++;
                r = W'($urandom_range(0, 511));
                in_data = r; drv_exp = sm2tc(r);
            end
        end
        @(negedge clk);
        check("bp_accepts", stall_acc, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(in_data, drv_exp);
        for (int i = 0; i < 4; i++) begin
            r = W'($urandom_range(0, 511));
            send(r, sm2tc(r));
        end
        drain();

        // Random valid/ready for 1000 accepted samples.
        pulse_reset();
        clear_stats();
        n = 0;
        while (acc_cnt < 1000 && n < 20000) begin
            in_valid  = 1'($urandom_range(0, 1));
            r         = W'($urandom_range(0, 511));
            in_data   = r;
            drv_exp   = sm2tc(r);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        check("rand_accepts", acc_cnt, 1000);
        drain();
        check("rand_frame_done", fd_cnt, 1000 / FRAME_LEN);

        // Reset with both registers full at count 3.
        pulse_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r = W'($urandom_range(0, 511));
            send(r, sm2tc(r));
        end
        out_ready = 1'b0;
        r = W'($urandom_range(0, 511));
        send(r, sm2tc(r));
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        pulse_reset();
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        clear_stats();
        out_ready = 1'b1;
        for (int i = 0; i < FRAME_LEN; i++) begin
            r = W'($urandom_range(0, 511));
            send(r, sm2tc(r));
        end
        drain();
        check("mid_rst_outputs", fire_cnt, FRAME_LEN);
        check("mid_rst_frame_done", fd_cnt, 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
